alu_exec_stage: RTL

Execute-stage datapath that sits directly downstream of the ALU control decoder: consumes its 4-bit `aluOP` code plus two 32-bit operands from the ID/EX register and delivers a registered result to the EX/MEM boundary under a valid/ready handshake. Shift operations run on an iterative 1-bit/cycle shifter unless the single-cycle barrel shifter is compiled in. The stage also absorbs downstream back-pressure and a pipeline flush.

---
 rtl/alu_exec_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU with registered, valid/ready result output.
// Shifts use an iterative 1-bit/cycle shifter by default; define
// ALU_EXEC_FAST_SHIFT_EN to replace it with a single-cycle barrel shifter.
module alu_exec_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] shreg;
    logic [XLEN-1:0] shreg_step;
    logic [4:0]      cnt;
    logic [4:0]      sh_rd;
    logic [1:0]      sh_kind;
    logic [4:0]      shamt;
    logic            is_shift;
    logic            accept;
    logic            go_shift;
    logic            sh_done;

    assign shamt    = op_b[4:0];
    assign is_shift = (alu_op == 4'd5) || (alu_op == 4'd6) || (alu_op == 4'd7);

    // single-cycle result for every op that completes on the accept edge
    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0: alu_res = op_a + op_b;
            4'd1: alu_res = op_a - op_b;
            4'd2: alu_res = op_a ^ op_b;
            4'd3: alu_res = op_a | op_b;
            4'd4: alu_res = op_a & op_b;
`ifdef ALU_EXEC_FAST_SHIFT_EN
            4'd5: alu_res = op_a << shamt;
            4'd6: alu_res = op_a >> shamt;
            4'd7: alu_res = $unsigned($signed(op_a) >>> shamt);
`else
            // only reached with shamt == 0; nonzero amounts go through SHIFT
            4'd5, 4'd6, 4'd7: alu_res = op_a;
`endif
            4'd8: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'd9: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: alu_res = '0;
        endcase
    end

    // one-bit step of the iterative shifter (kind = low bits of the shift op code)
    always_comb begin
        shreg_step = shreg;
        case (sh_kind)
            2'b01:   shreg_step = shreg << 1;
            2'b10:   shreg_step = shreg >> 1;
            default: shreg_step = {shreg[XLEN-1], shreg[XLEN-1:1]};
        endcase
    end

    // handshake, accept decode and next-state logic
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
        accept    = in_valid && in_ready;
`ifdef ALU_EXEC_FAST_SHIFT_EN
        go_shift  = 1'b0;
        busy      = 1'b0;
`else
        go_shift  = accept && is_shift && (shamt != 5'd0);
        busy      = (state == SHIFT);
`endif
        sh_done   = (state == SHIFT) && (cnt == 5'd1);
        case (state)
            IDLE:    if (go_shift) state_nxt = SHIFT;
            SHIFT:   if (flush || sh_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // output register and shifter datapath; flush outranks everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            shreg      <= '0;
            cnt        <= '0;
            sh_rd      <= '0;
            sh_kind    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else if (accept && !go_shift) begin
            out_valid  <= 1'b1;
            out_result <= alu_res;
            out_rd     <= rd_in;
        end else if (go_shift) begin
            // previous result (if any) retires on this edge since in_ready implied out_ready
            out_valid <= 1'b0;
            shreg     <= op_a;
            cnt       <= shamt;
            sh_rd     <= rd_in;
            sh_kind   <= alu_op[1:0];
        end else if (state == SHIFT) begin
            shreg <= shreg_step;
            cnt   <= cnt - 5'd1;
            if (sh_done) begin
                out_valid  <= 1'b1;
                out_result <= shreg_step;
                out_rd     <= sh_rd;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
